// File: rtl/fpnew_slice_result_collector_pkg.sv
// Shared types and constants for the slice result collector.
// Optional sticky-status feature is enabled by defining FPNEW_COLLECTOR_STICKY_STATUS_EN.
package fpnew_slice_result_collector_pkg;

  // IEEE exception flags in fpnew order: invalid, div-by-zero, overflow, underflow, inexact.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of_;
    logic uf;
    logic nx;
  } status_t;

  localparam int unsigned COLLECTOR_FIFO_DEPTH = 2;

  function automatic int unsigned src_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_slice_result_collector_if.sv
// Handshake bundle between the format slices, the collector and the FPU output side.
// Used by fpnew_slice_result_collector; optional FPNEW_COLLECTOR_STICKY_STATUS_EN ports live on the top.
interface fpnew_slice_result_collector_if #(
  parameter int unsigned NumInputs   = 4,
  parameter int unsigned Width       = 64,
  parameter int unsigned TagWidth    = 8,
  parameter int unsigned SrcIdxWidth = 2
);
  import fpnew_slice_result_collector_pkg::*;

  // Valid/ready: a transfer happens on a rising clock edge where both valid and ready
  // are high; the sender holds its bundle while valid is high and ready is low.
  logic [NumInputs-1:0]               in_valid_i;
  logic [NumInputs-1:0]               in_ready_o;
  logic [NumInputs-1:0][Width-1:0]    in_result_i;
  status_t [NumInputs-1:0]            in_status_i;
  logic [NumInputs-1:0]               in_ext_bit_i;
  logic [NumInputs-1:0][TagWidth-1:0] in_tag_i;

  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [Width-1:0]       result_o;
  status_t                status_o;
  logic                   extension_bit_o;
  logic [TagWidth-1:0]    tag_o;
  logic [SrcIdxWidth-1:0] src_idx_o;

  modport slave (
    input  in_valid_i, in_result_i, in_status_i, in_ext_bit_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, status_o, extension_bit_o, tag_o, src_idx_o
  );

  modport master (
    output in_valid_i, in_result_i, in_status_i, in_ext_bit_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, status_o, extension_bit_o, tag_o, src_idx_o
  );

endinterface

// File: rtl/fpnew_slice_result_collector_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr_i, wrapping at NumInputs-1.
// The priority pointer register is owned by the instantiating collector.
module fpnew_rr_arbiter #(
  parameter int unsigned NumInputs = 4,
  parameter int unsigned IdxWidth  = 2
) (
  input  logic [NumInputs-1:0] req_i,
  input  logic [IdxWidth-1:0]  ptr_i,
  output logic [NumInputs-1:0] gnt_onehot_o,
  output logic [IdxWidth-1:0]  gnt_idx_o,
  output logic                 valid_any_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    idx          = 0;
    for (int i = 0; i < int'(NumInputs); i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= int'(NumInputs)) idx = idx - int'(NumInputs);
      if (!found && req_i[idx]) begin
        found             = 1'b1;
        gnt_onehot_o[idx] = 1'b1;
        gnt_idx_o         = IdxWidth'(idx);
      end
    end
    valid_any_o = |req_i;
  end

endmodule

// File: rtl/fpnew_slice_result_collector.sv
// Collects per-slice results round-robin into a 2-entry FIFO feeding one output stream.
// Define FPNEW_COLLECTOR_STICKY_STATUS_EN to add sticky_status_o / clear_status_i.
module fpnew_slice_result_collector
  import fpnew_slice_result_collector_pkg::*;
#(
  parameter int unsigned NumInputs   = 4,
  parameter int unsigned Width       = 64,
  parameter int unsigned TagWidth    = 8,
  parameter int unsigned SrcIdxWidth = src_idx_width(NumInputs)
) (
  input  logic clk_i,
  input  logic rst_i,
  fpnew_slice_result_collector_if.slave bus,
  input  logic flush_i,
  output logic busy_o
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
  ,
  output status_t sticky_status_o,
  input  logic    clear_status_i
`endif
);

  localparam int unsigned PtrWidth = $clog2(COLLECTOR_FIFO_DEPTH);
  localparam int unsigned CntWidth = $clog2(COLLECTOR_FIFO_DEPTH + 1);
  localparam logic [CntWidth-1:0]    FullCnt = CntWidth'(COLLECTOR_FIFO_DEPTH);
  localparam logic [SrcIdxWidth-1:0] LastIdx = SrcIdxWidth'(NumInputs - 1);

  typedef struct packed {
    logic [Width-1:0]       result;
    status_t                status;
    logic                   ext_bit;
    logic [TagWidth-1:0]    tag;
    logic [SrcIdxWidth-1:0] src_idx;
  } collector_entry_t;

  collector_entry_t fifo_q [COLLECTOR_FIFO_DEPTH];
  collector_entry_t wr_entry;
  collector_entry_t head;

  logic [PtrWidth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0]    count_q, count_d;
  logic [SrcIdxWidth-1:0] rr_ptr_q, rr_ptr_d;

  logic [NumInputs-1:0]   gnt_onehot;
  logic [SrcIdxWidth-1:0] gnt_idx;
  logic                   valid_any;
  logic                   space;
  logic                   push;
  logic                   pop;

  fpnew_rr_arbiter #(
    .NumInputs (NumInputs),
    .IdxWidth  (SrcIdxWidth)
  ) i_arbiter (
    .req_i        (bus.in_valid_i),
    .ptr_i        (rr_ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .valid_any_o  (valid_any)
  );

  // Space depends only on registered count, so ready never follows out_ready_i
  // combinationally; holding ready low in reset keeps stray handshakes out.
  assign space          = (count_q < FullCnt) & ~flush_i & ~rst_i;
  assign bus.in_ready_o = gnt_onehot & {NumInputs{space}};
  assign push           = valid_any & space;
  assign pop            = bus.out_valid_o & bus.out_ready_i;

  always_comb begin
    wr_entry         = '0;
    wr_entry.result  = bus.in_result_i[gnt_idx];
    wr_entry.status  = bus.in_status_i[gnt_idx];
    wr_entry.ext_bit = bus.in_ext_bit_i[gnt_idx];
    wr_entry.tag     = bus.in_tag_i[gnt_idx];
    wr_entry.src_idx = gnt_idx;
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (push) rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < COLLECTOR_FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Outputs come straight from the head slot, so they hold while the sink stalls.
  assign head                = fifo_q[rd_ptr_q];
  assign bus.out_valid_o     = (count_q != '0);
  assign bus.result_o        = head.result;
  assign bus.status_o        = head.status;
  assign bus.extension_bit_o = head.ext_bit;
  assign bus.tag_o           = head.tag;
  assign bus.src_idx_o       = head.src_idx;

  assign busy_o = (count_q != '0) | (|bus.in_valid_i);

`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
  status_t sticky_q, sticky_d;

  // A pop coinciding with a clear still lands in the freshly cleared value.
  always_comb begin
    sticky_d = clear_status_i ? status_t'('0) : sticky_q;
    if (pop) sticky_d = status_t'(sticky_d | head.status);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_status_o = sticky_q;
`endif

endmodule

// File: tb/tb_fpnew_slice_result_collector.sv
// Self-checking bench for fpnew_slice_result_collector (default 4 inputs, 64-bit results).
// Sticky-status checks are included when FPNEW_COLLECTOR_STICKY_STATUS_EN is defined.
module tb_fpnew_slice_result_collector;
  import fpnew_slice_result_collector_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TW = 8;
  localparam int SW = 2;
  localparam int EW = W + 5 + 1 + TW + SW;

  logic clk;
  logic rst;
  logic flush;
  logic busy;
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
  status_t sticky;
  logic    clear_status;
`endif

  int checks;
  int errors;

  logic [EW-1:0] exp_q[$];
  int            rr_model;
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
  logic [4:0]    sticky_model;
`endif

  fpnew_slice_result_collector_if #(.NumInputs(N), .Width(W), .TagWidth(TW), .SrcIdxWidth(SW)) bus ();

  fpnew_slice_result_collector #(.NumInputs(N), .Width(W), .TagWidth(TW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .flush_i (flush),
    .busy_o  (busy)
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
    ,
    .sticky_status_o (sticky),
    .clear_status_i  (clear_status)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.in_valid_i   = '0;
    bus.in_result_i  = '0;
    bus.in_status_i  = '0;
    bus.in_ext_bit_i = '0;
    bus.in_tag_i     = '0;
    bus.out_ready_i  = 1'b0;
    flush            = 1'b0;
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
    clear_status     = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.in_valid_i = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", bus.in_ready_o); end
      checks++;
      if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
      checks++;
      if (bus.result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result_o); end
      checks++;
      if (bus.status_o !== status_t'(5'b0)) begin errors++; $display("FAIL reset_status got %b want 00000", bus.status_o); end
      checks++;
      if (bus.extension_bit_o !== 1'b0) begin errors++; $display("FAIL reset_ext got %b want 0", bus.extension_bit_o); end
      checks++;
      if (bus.tag_o !== 8'h0) begin errors++; $display("FAIL reset_tag got %h want 00", bus.tag_o); end
      checks++;
      if (bus.src_idx_o !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", bus.src_idx_o); end
    end
    bus.in_valid_i = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_push();
    bus.in_valid_i     = 4'b0100;
    bus.in_result_i[2] = 64'hDEAD_BEEF;
    bus.in_tag_i[2]    = 8'h5A;
    bus.in_status_i[2] = status_t'(5'b00001);
    bus.in_ext_bit_i[2] = 1'b1;
    bus.out_ready_i    = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", bus.in_ready_o); end
    next_cycle();
    bus.in_valid_i = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.out_valid_o); end
    checks++;
    if (bus.result_o !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_result got %h want deadbeef", bus.result_o); end
    checks++;
    if (bus.tag_o !== 8'h5A) begin errors++; $display("FAIL single_tag got %h want 5a", bus.tag_o); end
    checks++;
    if (bus.status_o !== status_t'(5'b00001)) begin errors++; $display("FAIL single_status got %b want 00001", bus.status_o); end
    checks++;
    if (bus.extension_bit_o !== 1'b1) begin errors++; $display("FAIL single_ext got %b want 1", bus.extension_bit_o); end
    checks++;
    if (bus.src_idx_o !== 2'd2) begin errors++; $display("FAIL single_src got %0d want 2", bus.src_idx_o); end
    next_cycle();
    bus.in_valid_i = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained got %b want 0", bus.out_valid_o); end
    checks++;
    if (bus.in_ready_o !== 4'b1000) begin errors++; $display("FAIL single_rr_next got %b want 1000", bus.in_ready_o); end
    bus.in_valid_i = '0;
    next_cycle();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.in_valid_i  = 4'b1111;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready_o !== (4'b0001 << (c % 4))) begin
        errors++; $display("FAIL rr_grant cycle %0d got %b want %b", c, bus.in_ready_o, 4'b0001 << (c % 4));
      end
      checks++;
      if (bus.out_valid_o !== (c > 0)) begin errors++; $display("FAIL rr_out_valid cycle %0d got %b", c, bus.out_valid_o); end
      if (c > 0) begin
        checks++;
        if (bus.src_idx_o !== SW'((c - 1) % 4)) begin
          errors++; $display("FAIL rr_src cycle %0d got %0d want %0d", c, bus.src_idx_o, (c - 1) % 4);
        end
      end
      next_cycle();
    end
    bus.in_valid_i = '0;
    next_cycle();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res [N];
    do_reset();
    for (int i = 0; i < N; i++) begin
      res[i] = {$urandom, $urandom};
      bus.in_result_i[i] = res[i];
    end
    bus.in_valid_i  = 4'b1111;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b want 0001", bus.in_ready_o); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b want 0010", bus.in_ready_o); end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.out_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_full_ready cycle %0d got %b want 0000", c, bus.in_ready_o); end
      checks++;
      if (bus.src_idx_o !== 2'd0 || bus.result_o !== res[0] || bus.out_valid_o !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d got src %0d res %h want src 0 res %h", c, bus.src_idx_o, bus.result_o, res[0]);
      end
      next_cycle();
    end
    bus.in_valid_i = '0;
    @(negedge clk);
    checks++;
    if (bus.src_idx_o !== 2'd1 || bus.result_o !== res[1] || bus.out_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_second got src %0d res %h want src 1 res %h", bus.src_idx_o, bus.result_o, res[1]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", bus.out_valid_o); end
    bus.out_ready_i = 1'b0;
    next_cycle();
  endtask

  task automatic test_flush();
    do_reset();
    bus.in_valid_i  = 4'b1111;
    bus.out_ready_i = 1'b0;
    next_cycle();
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 4'b0000) begin errors++; $display("FAIL flush_ready got %b want 0000", bus.in_ready_o); end
    checks++;
    if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_full_valid got %b want 1", bus.out_valid_o); end
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_cleared got %b want 0", bus.out_valid_o); end
    checks++;
    if (bus.in_ready_o !== 4'b0100) begin errors++; $display("FAIL flush_rr_kept got %b want 0100", bus.in_ready_o); end
    bus.in_valid_i = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    next_cycle();
  endtask

`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
  task automatic test_sticky();
    do_reset();
    bus.out_ready_i    = 1'b1;
    bus.in_valid_i     = 4'b0001;
    bus.in_status_i[0] = status_t'(5'b00001);
    next_cycle();
    bus.in_valid_i     = 4'b0010;
    bus.in_status_i[1] = status_t'(5'b10000);
    @(negedge clk);
    checks++;
    if (sticky !== status_t'(5'b0)) begin errors++; $display("FAIL sticky_before_pop got %b want 00000", sticky); end
    next_cycle();
    bus.in_valid_i = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (sticky !== status_t'(5'b10001)) begin errors++; $display("FAIL sticky_or got %b want 10001", sticky); end
    clear_status = 1'b1;
    next_cycle();
    clear_status = 1'b0;
    @(negedge clk);
    checks++;
    if (sticky !== status_t'(5'b0)) begin errors++; $display("FAIL sticky_clear got %b want 00000", sticky); end
    bus.out_ready_i = 1'b0;
    next_cycle();
  endtask
`endif

  // Random traffic against a queue model: arbitration rule, 2-deep buffering, flush.
  task automatic test_random();
    int            k;
    bit            found;
    bit            exp_push;
    bit            exp_pop;
    logic [N-1:0]  exp_ready;
    logic [EW-1:0] got_head;
    logic [EW-1:0] new_entry;
    do_reset();
    exp_q.delete();
    rr_model = 0;
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
    sticky_model = '0;
`endif
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.in_valid_i  = N'($urandom_range(0, 15));
      bus.out_ready_i = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 19) == 0);
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
      clear_status    = ($urandom_range(0, 15) == 0);
`endif
      for (int i = 0; i < N; i++) begin
        bus.in_result_i[i]  = {$urandom, $urandom};
        bus.in_status_i[i]  = status_t'($urandom_range(0, 31));
        bus.in_ext_bit_i[i] = 1'($urandom_range(0, 1));
        bus.in_tag_i[i]     = TW'($urandom_range(0, 255));
      end
      @(negedge clk);
      found = 0;
      k = 0;
      for (int j = 0; j < N; j++) begin
        int cand;
        cand = (rr_model + j) % N;
        if (!found && bus.in_valid_i[cand]) begin found = 1; k = cand; end
      end
      exp_push  = found && (exp_q.size() < 2) && !flush;
      exp_pop   = (exp_q.size() != 0) && bus.out_ready_i;
      exp_ready = exp_push ? (N'(1) << k) : '0;
      checks++;
      if (bus.in_ready_o !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, bus.in_ready_o, exp_ready); end
      checks++;
      if (bus.out_valid_o !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, bus.out_valid_o, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        got_head = {bus.result_o, bus.status_o, bus.extension_bit_o, bus.tag_o, bus.src_idx_o};
        checks++;
        if (got_head !== exp_q[0]) begin errors++; $display("FAIL rand_head cyc %0d got %h want %h", cyc, got_head, exp_q[0]); end
      end
      checks++;
      if (busy !== ((exp_q.size() != 0) || (|bus.in_valid_i))) begin errors++; $display("FAIL rand_busy cyc %0d got %b", cyc, busy); end
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
      checks++;
      if (sticky !== status_t'(sticky_model)) begin errors++; $display("FAIL rand_sticky cyc %0d got %b want %b", cyc, sticky, sticky_model); end
      if (clear_status) sticky_model = '0;
      if (exp_pop) sticky_model = sticky_model | exp_q[0][EW-W-1 -: 5];
`endif
      new_entry = {bus.in_result_i[k], bus.in_status_i[k], bus.in_ext_bit_i[k], bus.in_tag_i[k], SW'(k)};
      @(posedge clk);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_pop) void'(exp_q.pop_front());
        if (exp_push) exp_q.push_back(new_entry);
      end
      if (exp_push) rr_model = (k + 1) % N;
      #1;
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_flush();
`ifdef FPNEW_COLLECTOR_STICKY_STATUS_EN
    test_sticky();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
